// File: rtl/dm_lsu_pkg.sv
// Shared encodings for the dm_lsu load/store unit: access sizes, FSM states
// and the data-memory word-index width.
package dm_lsu_pkg;

    localparam int DM_AW = 7;

    typedef enum logic [1:0] {
        OP_BYTE = 2'b00,
        OP_HALF = 2'b01,
        OP_WORD = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        ACK  = 2'b11
    } state_e;

endpackage

// File: rtl/dm_lsu_if.sv
// Request/response bus between the MEM stage (master) and dm_lsu (slave).
interface dm_lsu_if;
    logic        req;
    logic        we;
    logic [1:0]  op;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, op, sext, addr, wdata,
                    input  busy, ack, rdata, err);
    modport slave  (input  req, we, op, sext, addr, wdata,
                    output busy, ack, rdata, err);
endinterface

// File: rtl/dm_lsu_lane.sv
// Combinational lane logic: sub-word store merge and load extract/extend.
// Any size other than byte/halfword is handled as a full word.
module dm_lsu_lane
    import dm_lsu_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [31:0] word,
    input  logic [1:0]  op,
    input  logic [1:0]  off,
    input  logic        sext,
    output logic [31:0] merged,
    output logic [31:0] loaded
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        merged = data;
        case (op)
            OP_BYTE: begin
                merged = old_word;
                merged[{off, 3'b000} +: 8] = data[7:0];
            end
            OP_HALF: begin
                merged = old_word;
                merged[{off[1], 4'b0000} +: 16] = data[15:0];
            end
            default: merged = data;
        endcase
    end

    // Halfword lane comes from addr[1] only; addr[0] never moves the lane.
    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = word[{off[1], 4'b0000} +: 16];
        case (op)
            OP_BYTE: loaded = {{24{sext & byte_sel[7]}}, byte_sel};
            OP_HALF: loaded = {{16{sext & half_sel[15]}}, half_sel};
            default: loaded = word;
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit driving the word-only data memory; sub-word stores are
// read-modify-write. Define DM_LSU_ALIGN_CHECK_EN to flag misaligned/illegal accesses.
module dm_lsu
    import dm_lsu_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    dm_lsu_if.slave          bus,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_din,
    output logic             dm_wr,
    input  logic [31:0]      dm_dout
);

    state_e      state, state_nxt;
    logic        we_q, sext_q, err_q;
    logic [1:0]  op_q;
    logic [8:0]  addr_q;
    logic [31:0] wdata_q, word_q, rdata_q;
    logic        accept, sub_w, err_w;
    logic [31:0] merged, loaded;
    logic        unused_addr;

    assign unused_addr = ^bus.addr[31:9];
    assign accept      = (state == IDLE) && bus.req;
    assign sub_w       = (bus.op == OP_BYTE) || (bus.op == OP_HALF);

`ifdef DM_LSU_ALIGN_CHECK_EN
    always_comb begin
        case (bus.op)
            OP_BYTE: err_w = 1'b0;
            OP_HALF: err_w = bus.addr[0];
            OP_WORD: err_w = (bus.addr[1:0] != 2'b00);
            default: err_w = 1'b1;
        endcase
    end
`else
    assign err_w = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Errors spend the RD slot idle so they complete with load latency.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req) state_nxt = (bus.we && !sub_w && !err_w) ? WR : RD;
            RD:      state_nxt = (we_q && !err_q) ? WR : ACK;
            WR:      state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.ack  = (state == ACK);
        bus.err  = (state == ACK) && err_q;
        dm_wr    = (state == WR);
        dm_addr  = (state == IDLE) ? '0 : addr_q[8:2];
        dm_din   = (state == WR) ? merged : '0;
    end

    assign bus.rdata = rdata_q;

    // Request fields latched at accept; read word captured during RD
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.we;
            op_q    <= bus.op;
            sext_q  <= bus.sext;
            addr_q  <= bus.addr[8:0];
            wdata_q <= bus.wdata;
        end
        if (state == RD) word_q <= dm_dout;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) err_q <= err_w;
            if (state == RD || state == WR)
                rdata_q <= (state == RD && !we_q && !err_q) ? loaded : '0;
        end
    end

    dm_lsu_lane u_lane (
        .old_word (word_q),
        .data     (wdata_q),
        .word     (dm_dout),
        .op       (op_q),
        .off      (addr_q[1:0]),
        .sext     (sext_q),
        .merged   (merged),
        .loaded   (loaded)
    );

endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu with a behavioural data-memory model.
module tb_dm_lsu;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [6:0]  dm_addr;
    logic [31:0] dm_din;
    logic        dm_wr;
    logic [31:0] dm_dout;

    dm_lsu_if bus();

    dm_lsu dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .dm_addr (dm_addr),
        .dm_din  (dm_din),
        .dm_wr   (dm_wr),
        .dm_dout (dm_dout)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [128];
    assign dm_dout = mem[dm_addr];
    always @(posedge clk) if (dm_wr) mem[dm_addr] <= dm_din;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int cyc; bit chk_rd; logic [31:0] rd; logic er; } ack_t;
    typedef struct { int cyc; logic [6:0] a; logic [31:0] d; } wr_t;
    ack_t sq[$];
    wr_t  wq[$];
    logic [31:0] ref_mem [128];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: access rules applied with plain arithmetic on a word array
    task automatic expect_acc(input bit w, input logic [1:0] o, input bit s,
                              input logic [31:0] a, input logic [31:0] d, input int c,
                              input bit has_k, input logic [31:0] k);
        ack_t e;
        wr_t  wr;
        int   idx, off, sh, lat;
        logic [31:0] mask, v, old;
        bit   bad;
        idx = int'(a[8:2]);
        off = int'(a[1:0]);
`ifdef DM_LSU_ALIGN_CHECK_EN
        bad = (o == 2'd1 && (off % 2) == 1) || (o == 2'd2 && off != 0) || (o == 2'd3);
`else
        bad = 1'b0;
`endif
        sh   = (o == 2'd0) ? 8 * off : (o == 2'd1) ? 16 * (off / 2) : 0;
        mask = (o == 2'd0) ? 32'hFF : (o == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        old  = ref_mem[idx];
        lat  = (!bad && w && o < 2'd2) ? 3 : 2;
        e.cyc = c + lat;
        e.er  = bad;
        e.chk_rd = bad || !w;
        e.rd  = 32'h0;
        if (!bad && w) begin
            v = (old & ~(mask << sh)) | ((d & mask) << sh);
            ref_mem[idx] = v;
            wr.cyc = c + lat - 1;
            wr.a   = 7'(idx);
            wr.d   = has_k ? k : v;
            wq.push_back(wr);
        end else if (!bad) begin
            v = (old >> sh) & mask;
            if (s && o == 2'd0 && v >= 32'h80)   v = v | 32'hFFFF_FF00;
            if (s && o == 2'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            e.rd = has_k ? k : v;
        end else if (has_k) begin
            e.rd = k;
        end
        sq.push_back(e);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (bus.busy && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 20) chk("busy_timeout", {31'b0, bus.busy}, 32'h0);
    endtask

    task automatic drive(input bit w, input logic [1:0] o, input bit s,
                         input logic [31:0] a, input logic [31:0] d);
        bus.req = 1'b1; bus.we = w; bus.op = o; bus.sext = s;
        bus.addr = a; bus.wdata = d;
    endtask

    task automatic issue(input bit w, input logic [1:0] o, input bit s,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit has_k, input logic [31:0] k);
        wait_idle();
        drive(w, o, s, a, d);
        expect_acc(w, o, s, a, d, cyc, has_k, k);
        @(posedge clk); #1;
        bus.req = 1'b0;
        bus.addr = $urandom; bus.wdata = $urandom;
    endtask

    always @(negedge clk) begin
        ack_t e;
        wr_t  w;
        if (rstn) begin
            if (!bus.busy) chk("dm_addr_idle", {25'b0, dm_addr}, 32'h0);
            if (bus.ack) begin
                if (sq.size() == 0) chk("ack_unexpected", {31'b0, bus.ack}, 32'h0);
                else begin
                    e = sq.pop_front();
                    chk("ack_cycle", cyc, e.cyc);
                    chk("err", {31'b0, bus.err}, {31'b0, e.er});
                    if (e.chk_rd) chk("rdata", bus.rdata, e.rd);
                end
            end
            if (dm_wr) begin
                if (wq.size() == 0) chk("wr_unexpected", {31'b0, dm_wr}, 32'h0);
                else begin
                    w = wq.pop_front();
                    chk("wr_cycle", cyc, w.cyc);
                    chk("dm_addr", {25'b0, dm_addr}, {25'b0, w.a});
                    chk("dm_din", dm_din, w.d);
                end
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"},    {31'b0, bus.busy},  32'h0);
        chk({tag, "_ack"},     {31'b0, bus.ack},   32'h0);
        chk({tag, "_err"},     {31'b0, bus.err},   32'h0);
        chk({tag, "_rdata"},   bus.rdata,          32'h0);
        chk({tag, "_dm_wr"},   {31'b0, dm_wr},     32'h0);
        chk({tag, "_dm_addr"}, {25'b0, dm_addr},   32'h0);
        chk({tag, "_dm_din"},  dm_din,             32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int c;
        bus.req = 1'b0; bus.we = 1'b0; bus.op = 2'd0; bus.sext = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'h0;
        for (int i = 0; i < 128; i++) begin
            v = $urandom;
            mem[i] <= v;
            ref_mem[i] = v;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 1, 32'hDEADBEEF);
        issue(0, 2'd2, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF);
        issue(1, 2'd2, 0, 32'h10, 32'h11223344, 0, 32'h0);
        issue(1, 2'd0, 0, 32'h13, 32'h555555AA, 1, 32'hAA223344);
        issue(0, 2'd2, 0, 32'h10, 32'h0, 1, 32'hAA223344);

        issue(1, 2'd2, 0, 32'h20, 32'h8000F07F, 0, 32'h0);
        issue(0, 2'd0, 1, 32'h20, 32'h0, 1, 32'h0000007F);
        issue(0, 2'd0, 1, 32'h21, 32'h0, 1, 32'hFFFFFFF0);
        issue(0, 2'd1, 1, 32'h22, 32'h0, 1, 32'hFFFF8000);
        issue(0, 2'd1, 0, 32'h22, 32'h0, 1, 32'h00008000);
        issue(0, 2'd0, 1, 32'h23, 32'h0, 1, 32'hFFFFFF80);
        issue(0, 2'd0, 0, 32'h23, 32'h0, 1, 32'h00000080);
`ifdef DM_LSU_ALIGN_CHECK_EN
        issue(0, 2'd1, 0, 32'h21, 32'h0, 1, 32'h00000000);
`else
        issue(0, 2'd1, 0, 32'h21, 32'h0, 1, 32'h0000F07F);
`endif
        issue(1, 2'd2, 0, 32'h230, 32'h12345678, 0, 32'h0);
        issue(0, 2'd2, 0, 32'h30, 32'h0, 1, 32'h12345678);

        // req held high: second access only after ack, with the new fields
        wait_idle();
        c = cyc;
        drive(0, 2'd2, 0, 32'h20, 32'h0);
        expect_acc(0, 2'd2, 0, 32'h20, 32'h0, c, 1, 32'h8000F07F);
        @(posedge clk); #1;
        bus.addr = 32'h22; bus.op = 2'd1; bus.sext = 1'b1;
        expect_acc(0, 2'd1, 1, 32'h22, 32'h0, c + 3, 1, 32'hFFFF8000);
        repeat (3) @(posedge clk);
        #1;
        bus.req = 1'b0;

        // reset during RD of a sub-word store aborts it
        issue(1, 2'd2, 0, 32'h40, 32'h55667788, 0, 32'h0);
        wait_idle();
        drive(1, 2'd0, 0, 32'h41, 32'h00000099);
        @(posedge clk); #1;
        bus.req = 1'b0;
        rstn = 1'b0;
        #1;
        chk_zero_outputs("rst_rd");
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        issue(0, 2'd2, 0, 32'h40, 32'h0, 1, 32'h55667788);

        for (int i = 0; i < 200; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 32'h3FF)), $urandom, 0, 32'h0);
        end

        for (int g = 0; g < 20 && (sq.size() != 0 || wq.size() != 0); g++) begin
            @(posedge clk); #1;
        end
        chk("sb_drain", sq.size(), 32'h0);
        chk("wr_drain", wq.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
